pll_sequencer: RTL

PLL_SEQUENCER -- requirements
Module: pll_sequencer

---
 rtl/pll_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pll_sequencer.sv
// rtl/pll_sequencer.sv - PLL reset/lock sequencer with timeout retries and output qualification
//
// Releases the PLL from reset and waits for a synchronized LOCK. It then
// requires a run of stable lock cycles before it qualifies the PLL output.
// A lock timeout counts as a failed attempt. Once the retries are used up,
// the block parks in a sticky fault state.
//
// Ports:
//   REFERENCECLK  in   reference clock, also fed to the PLL
//   RESETB        in   asynchronous active-low reset
//   LOCK          in   PLL lock indicator (asynchronous)
//   RESTART       in   synchronous pulse: restart the full relock sequence
//   PLL_RESETB    out  active-low reset to the PLL
//   CLK_EN        out  PLL output qualified for use
//   READY         out  high in RUN, same timing as CLK_EN
//   FAULT         out  sticky, retries exhausted
//   RETRY_CNT     out  failed attempts in the current sequence (saturating)
//   STATE         out  debug state: RST=0 WAIT=1 STABLE=2 RUN=3 FAIL=4

module pll_sequencer #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int STABLE_CYCLES = 256,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       REFERENCECLK,
   input  logic       RESETB,
   input  logic       LOCK,
   input  logic       RESTART,
   output logic       PLL_RESETB,
   output logic       CLK_EN,
   output logic       READY,
   output logic       FAULT,
   output logic [2:0] RETRY_CNT,
   output logic [2:0] STATE
);

   // Each counter only has to reach PARAM-1, which is its terminal value.
   localparam int RW = $clog2(RESET_CYCLES);
   localparam int TW = $clog2(LOCK_TIMEOUT);
   localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

   localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [2:0]    MAX_R    = 3'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_WAIT   = 3'd1,
      ST_STABLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_FAIL   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          lock_meta_q, lock_meta_d;
   logic          lock_s_q, lock_s_d;
   logic [RW-1:0] rst_cnt_q, rst_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [SW-1:0] stb_cnt_q, stb_cnt_d;
   logic [2:0]    retry_q, retry_d;
   logic          pll_resetb_q, pll_resetb_d;
   logic          clk_en_q, clk_en_d;
   logic          ready_q, ready_d;
   logic          fault_q, fault_d;

   always_comb begin
      lock_meta_d = LOCK;
      lock_s_d    = lock_meta_q;
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      to_cnt_d    = to_cnt_q;
      stb_cnt_d   = stb_cnt_q;
      retry_d     = retry_q;

      case (state_q)
         ST_RST: begin
            if (rst_cnt_q == RST_LAST) state_d = ST_WAIT;
            else                       rst_cnt_d = rst_cnt_q + 1'b1;
         end
         ST_WAIT: begin
            // Lock is checked first so that a lock arriving on the timeout cycle wins.
            if (lock_s_q) begin
               state_d = ST_STABLE;
            end else if (to_cnt_q == TO_LAST) begin
               if (retry_q < MAX_R) begin
                  retry_d = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
                  state_d = ST_RST;
               end else begin
                  state_d = ST_FAIL;
               end
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ST_STABLE: begin
            if (!lock_s_q)                 state_d = ST_WAIT;
            else if (stb_cnt_q == STB_LAST) state_d = ST_RUN;
            else                           stb_cnt_d = stb_cnt_q + 1'b1;
         end
         ST_RUN: begin
            if (!lock_s_q) state_d = ST_RST;
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: begin
            state_d = ST_RST;
         end
      endcase

      // Every state change starts the next phase with fresh counters.
      if (state_d != state_q) begin
         rst_cnt_d = '0;
         to_cnt_d  = '0;
         stb_cnt_d = '0;
      end

      if (state_d == ST_RUN && state_q != ST_RUN) retry_d = 3'd0;

      if (RESTART) begin
         state_d   = ST_RST;
         rst_cnt_d = '0;
         to_cnt_d  = '0;
         stb_cnt_d = '0;
         retry_d   = 3'd0;
      end

      // The outputs are decoded from the next state and registered. They
      // therefore change on the same edge as the state register.
      pll_resetb_d = (state_d == ST_WAIT) || (state_d == ST_STABLE) || (state_d == ST_RUN);
      clk_en_d     = (state_d == ST_RUN);
      ready_d      = (state_d == ST_RUN);
      fault_d      = (state_d == ST_FAIL);
   end

   always_ff @(posedge REFERENCECLK or negedge RESETB) begin
      if (!RESETB) begin
         state_q      <= ST_RST;
         lock_meta_q  <= 1'b0;
         lock_s_q     <= 1'b0;
         rst_cnt_q    <= '0;
         to_cnt_q     <= '0;
         stb_cnt_q    <= '0;
         retry_q      <= 3'd0;
         pll_resetb_q <= 1'b0;
         clk_en_q     <= 1'b0;
         ready_q      <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         lock_meta_q  <= lock_meta_d;
         lock_s_q     <= lock_s_d;
         rst_cnt_q    <= rst_cnt_d;
         to_cnt_q     <= to_cnt_d;
         stb_cnt_q    <= stb_cnt_d;
         retry_q      <= retry_d;
         pll_resetb_q <= pll_resetb_d;
         clk_en_q     <= clk_en_d;
         ready_q      <= ready_d;
         fault_q      <= fault_d;
      end
   end

   assign PLL_RESETB = pll_resetb_q;
   assign CLK_EN     = clk_en_q;
   assign READY      = ready_q;
   assign FAULT      = fault_q;
   assign RETRY_CNT  = retry_q;
   assign STATE      = state_q;

endmodule
